// File: rtl/fft_mem_rd_mux_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fft_mem_rd_mux_pkg
//  Purpose  : Shared FFT read-side definitions: default RAM read latency,
//             drain FSM state encoding and the bit-reversal helper used by
//             both the drain engine and the FFT address generator.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package fft_mem_rd_mux_pkg;

  // Default bank RAM read latency in cycles (legal values 1 or 2).
  localparam int c_rd_latency_def = 1;

  // Widest address the bit-reversal helper handles.
  localparam int c_bitrev_max_w = 16;

  typedef enum logic [1:0] {
    DRAIN_IDLE  = 2'd0,
    DRAIN_RUN   = 2'd1,
    DRAIN_FLUSH = 2'd2
  } drain_state_e;

  // Reverses the low w bits of a; bits at or above w come back as zero.
  function automatic logic [c_bitrev_max_w-1:0] bitrev(
    input logic [c_bitrev_max_w-1:0] a,
    input int                        w
  );
    logic [c_bitrev_max_w-1:0] r;
    r = '0;
    for (int i = 0; i < c_bitrev_max_w; i++) begin
      if (i < w) begin
        r[i] = a[w-1-i];
      end
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fft_rd_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : fft_rd_fifo
//  Purpose  : Small synchronous FIFO buffering drained samples ahead of the
//             valid/ready output. Head word is presented combinationally.
//  Ports    : clk, rst_n       clock, asynchronous active-low reset
//             push_i, din_i    write strobe and data (ignored when full)
//             pop_i            read strobe (ignored when empty)
//             dout_o           head-of-queue data
//             count_o          current occupancy
//             empty_o, full_o  occupancy flags
//  Revision : 1.0  initial release
// ============================================================================
module fft_rd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic [CW-1:0]    count_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam logic [CW-1:0] c_full  = CW'(DEPTH);
  localparam logic [CW-1:0] c_one   = CW'(1);
  localparam logic [PW-1:0] c_p_one = PW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == c_full);
  assign count_o   = count_q;
  assign dout_o    = mem_q[rd_ptr_q];
  assign w_push_ok = push_i && !full_o;
  assign w_pop_ok  = pop_i && !empty_o;

  // Storage has no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push_ok) begin
        wr_ptr_q <= wr_ptr_q + c_p_one;
      end
      if (w_pop_ok) begin
        rd_ptr_q <= rd_ptr_q + c_p_one;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   count_q <= count_q + c_one;
        2'b01:   count_q <= count_q - c_one;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/fft_mem_rd_mux.sv
`default_nettype none
// ============================================================================
//  Module   : fft_mem_rd_mux
//  Purpose  : Read-side mux for the FFT ping-pong result banks. Routes the
//             FFT core's A/B butterfly reads to the bank chosen by rmem_id,
//             realigns returned data to the RAM latency, and drains a
//             completed bank over valid/ready in bit-reversed order.
//  Ports    : clk, rst_n                    clock, async active-low reset
//             fft_raddra/b, fft_rea/b       FFT read requests
//             rmem_id                       bank the FFT reads from
//             fft_rdataa/b, fft_rvalida/b   FFT read responses
//             memN_addra/b, memN_ena/b      bank N read requests
//             memN_douta/b                  bank N read data
//             drain_start, drain_mem_id     drain launch and bank select
//             drain_busy, conflict_err      drain status, sticky collision
//             m_tdata/tvalid/tready/tlast   drained sample stream
//  Revision : 1.0  initial release
// ============================================================================
module fft_mem_rd_mux
  import fft_mem_rd_mux_pkg::*;
#(
  parameter int  FFT_SIZE   = 4096,
  parameter int  DATA_WIDTH = 64,
  parameter int  RD_LATENCY = c_rd_latency_def,
  parameter int  BITREV     = 1,
  parameter int  FIFO_DEPTH = 4,
  localparam int ADDR_WIDTH = $clog2(FFT_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] fft_raddra,
  input  logic [ADDR_WIDTH-1:0] fft_raddrb,
  input  logic                  fft_rea,
  input  logic                  fft_reb,
  input  logic                  rmem_id,
  output logic [DATA_WIDTH-1:0] fft_rdataa,
  output logic [DATA_WIDTH-1:0] fft_rdatab,
  output logic                  fft_rvalida,
  output logic                  fft_rvalidb,
  output logic [ADDR_WIDTH-1:0] mem0_addra,
  output logic [ADDR_WIDTH-1:0] mem0_addrb,
  output logic                  mem0_ena,
  output logic                  mem0_enb,
  input  logic [DATA_WIDTH-1:0] mem0_douta,
  input  logic [DATA_WIDTH-1:0] mem0_doutb,
  output logic [ADDR_WIDTH-1:0] mem1_addra,
  output logic [ADDR_WIDTH-1:0] mem1_addrb,
  output logic                  mem1_ena,
  output logic                  mem1_enb,
  input  logic [DATA_WIDTH-1:0] mem1_douta,
  input  logic [DATA_WIDTH-1:0] mem1_doutb,
  input  logic                  drain_start,
  input  logic                  drain_mem_id,
  output logic                  drain_busy,
  output logic                  conflict_err,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast
);

  localparam int c_cw = $clog2(FIFO_DEPTH) + 1;
  localparam logic [c_cw:0]       c_depth    = (c_cw+1)'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH:0] c_last_idx = (ADDR_WIDTH+1)'(FFT_SIZE - 1);
  localparam logic [ADDR_WIDTH:0] c_size     = (ADDR_WIDTH+1)'(FFT_SIZE);
  localparam logic [ADDR_WIDTH:0] c_cnt_one  = (ADDR_WIDTH+1)'(1);

  drain_state_e state_q, state_d;
  // One bit wider than the address so the terminal count never wraps.
  logic [ADDR_WIDTH:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH:0] beat_q, beat_d;
  logic                bank_q, bank_d;
  logic                conflict_q;

  // Per-stage {en, id} for FFT ports and issue flags for the drain.
  logic [RD_LATENCY-1:0] pa_en_q, pa_id_q;
  logic [RD_LATENCY-1:0] pb_en_q, pb_id_q;
  logic [RD_LATENCY-1:0] dr_q;

  logic                  w_busy;
  logic                  w_conflict;
  logic                  w_a_ok;
  logic                  w_issue;
  logic                  w_credit;
  logic                  w_push;
  logic                  w_pop;
  logic [ADDR_WIDTH-1:0] w_drain_addr;
  logic [c_cw-1:0]       w_fifo_count;
  logic [c_cw:0]         w_inflight;
  logic                  w_fifo_empty;
  logic                  w_fifo_full;
  logic [DATA_WIDTH-1:0] w_drain_data;
  logic [DATA_WIDTH-1:0] w_fifo_dout;

  assign w_busy       = (state_q != DRAIN_IDLE);
  assign drain_busy   = w_busy;
  assign conflict_err = conflict_q;

  // While draining, port A of the drained bank belongs to the drain engine.
  assign w_conflict = w_busy && fft_rea && (rmem_id == bank_q);
  assign w_a_ok     = fft_rea && !w_conflict;

  assign w_drain_addr = (BITREV != 0)
    ? ADDR_WIDTH'(bitrev(c_bitrev_max_w'(cnt_q[ADDR_WIDTH-1:0]), ADDR_WIDTH))
    : cnt_q[ADDR_WIDTH-1:0];

  // ---------------------------------------------------------------- routing
  always_comb begin
    mem0_addra = '0;
    mem0_addrb = '0;
    mem0_ena   = 1'b0;
    mem0_enb   = 1'b0;
    mem1_addra = '0;
    mem1_addrb = '0;
    mem1_ena   = 1'b0;
    mem1_enb   = 1'b0;
    if (w_a_ok) begin
      if (rmem_id) begin
        mem1_ena   = 1'b1;
        mem1_addra = fft_raddra;
      end else begin
        mem0_ena   = 1'b1;
        mem0_addra = fft_raddra;
      end
    end
    if (fft_reb) begin
      if (rmem_id) begin
        mem1_enb   = 1'b1;
        mem1_addrb = fft_raddrb;
      end else begin
        mem0_enb   = 1'b1;
        mem0_addrb = fft_raddrb;
      end
    end
    // An accepted FFT A read never targets the drained bank, so no overlap.
    if (w_busy) begin
      if (bank_q) begin
        mem1_ena   = w_issue;
        mem1_addra = w_drain_addr;
      end else begin
        mem0_ena   = w_issue;
        mem0_addra = w_drain_addr;
      end
    end
  end

  // ------------------------------------------------------ latency pipelines
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pa_en_q <= '0;
      pa_id_q <= '0;
      pb_en_q <= '0;
      pb_id_q <= '0;
      dr_q    <= '0;
    end else begin
      pa_en_q[0] <= w_a_ok;
      pa_id_q[0] <= rmem_id;
      pb_en_q[0] <= fft_reb;
      pb_id_q[0] <= rmem_id;
      dr_q[0]    <= w_issue;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pa_en_q[i] <= pa_en_q[i-1];
        pa_id_q[i] <= pa_id_q[i-1];
        pb_en_q[i] <= pb_en_q[i-1];
        pb_id_q[i] <= pb_id_q[i-1];
        dr_q[i]    <= dr_q[i-1];
      end
    end
  end

  assign fft_rvalida = pa_en_q[RD_LATENCY-1];
  assign fft_rvalidb = pb_en_q[RD_LATENCY-1];
  assign fft_rdataa  = !fft_rvalida ? '0 :
                       (pa_id_q[RD_LATENCY-1] ? mem1_douta : mem0_douta);
  assign fft_rdatab  = !fft_rvalidb ? '0 :
                       (pb_id_q[RD_LATENCY-1] ? mem1_doutb : mem0_doutb);

  // ------------------------------------------------------------ drain path
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      w_inflight = w_inflight + (c_cw+1)'(dr_q[i]);
    end
  end

  // Reads in flight already hold a FIFO slot, so the FIFO cannot overflow.
  assign w_credit     = (({1'b0, w_fifo_count} + w_inflight) < c_depth);
  assign w_drain_data = bank_q ? mem1_douta : mem0_douta;
  assign w_push       = dr_q[RD_LATENCY-1] && !w_fifo_full;
  assign w_pop        = !w_fifo_empty && m_tready;

  fft_rd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (w_push),
    .din_i   (w_drain_data),
    .pop_i   (w_pop),
    .dout_o  (w_fifo_dout),
    .count_o (w_fifo_count),
    .empty_o (w_fifo_empty),
    .full_o  (w_fifo_full)
  );

  assign m_tvalid = !w_fifo_empty;
  assign m_tdata  = w_fifo_dout;
  assign m_tlast  = m_tvalid && (beat_q == c_last_idx);

  // -------------------------------------------------------------- drain FSM
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    bank_d  = bank_q;
    w_issue = 1'b0;
    if (w_pop) begin
      beat_d = beat_q + c_cnt_one;
    end
    case (state_q)
      DRAIN_IDLE: begin
        if (drain_start) begin
          state_d = DRAIN_RUN;
          cnt_d   = '0;
          beat_d  = '0;
          bank_d  = drain_mem_id;
        end
      end
      DRAIN_RUN: begin
        if (w_credit) begin
          w_issue = 1'b1;
          cnt_d   = cnt_q + c_cnt_one;
          if (cnt_q == c_last_idx) begin
            state_d = DRAIN_FLUSH;
          end
        end
      end
      DRAIN_FLUSH: begin
        if ((w_inflight == '0) && w_fifo_empty && (beat_q == c_size)) begin
          state_d = DRAIN_IDLE;
        end
      end
      default: state_d = DRAIN_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= DRAIN_IDLE;
      cnt_q      <= '0;
      beat_q     <= '0;
      bank_q     <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      beat_q     <= beat_d;
      bank_q     <= bank_d;
      conflict_q <= conflict_q | w_conflict;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fft_mem_rd_mux.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fft_mem_rd_mux
//  Purpose  : Scoreboard bench for fft_mem_rd_mux with two modelled banks.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fft_mem_rd_mux;

  localparam int FFT_SIZE   = 16;
  localparam int AW         = 4;
  localparam int DW         = 64;
  localparam int RD_LAT     = 1;
  localparam int FIFO_DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0] fft_raddra = '0, fft_raddrb = '0;
  logic          fft_rea = 1'b0, fft_reb = 1'b0, rmem_id = 1'b0;
  logic [DW-1:0] fft_rdataa, fft_rdatab;
  logic          fft_rvalida, fft_rvalidb;
  logic [AW-1:0] mem0_addra, mem0_addrb, mem1_addra, mem1_addrb;
  logic          mem0_ena, mem0_enb, mem1_ena, mem1_enb;
  logic [DW-1:0] mem0_douta = '0, mem0_doutb = '0, mem1_douta = '0, mem1_doutb = '0;
  logic          drain_start = 1'b0, drain_mem_id = 1'b0;
  logic          drain_busy, conflict_err;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid, m_tlast;
  logic          m_tready = 1'b0;

  fft_mem_rd_mux #(
    .FFT_SIZE   (FFT_SIZE),
    .DATA_WIDTH (DW),
    .RD_LATENCY (RD_LAT),
    .BITREV     (1),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fft_raddra   (fft_raddra),
    .fft_raddrb   (fft_raddrb),
    .fft_rea      (fft_rea),
    .fft_reb      (fft_reb),
    .rmem_id      (rmem_id),
    .fft_rdataa   (fft_rdataa),
    .fft_rdatab   (fft_rdatab),
    .fft_rvalida  (fft_rvalida),
    .fft_rvalidb  (fft_rvalidb),
    .mem0_addra   (mem0_addra),
    .mem0_addrb   (mem0_addrb),
    .mem0_ena     (mem0_ena),
    .mem0_enb     (mem0_enb),
    .mem0_douta   (mem0_douta),
    .mem0_doutb   (mem0_doutb),
    .mem1_addra   (mem1_addra),
    .mem1_addrb   (mem1_addrb),
    .mem1_ena     (mem1_ena),
    .mem1_enb     (mem1_enb),
    .mem1_douta   (mem1_douta),
    .mem1_doutb   (mem1_doutb),
    .drain_start  (drain_start),
    .drain_mem_id (drain_mem_id),
    .drain_busy   (drain_busy),
    .conflict_err (conflict_err),
    .m_tdata      (m_tdata),
    .m_tvalid     (m_tvalid),
    .m_tready     (m_tready),
    .m_tlast      (m_tlast)
  );

  // Bank RAM models, one-cycle registered read.
  logic [DW-1:0] bank0 [FFT_SIZE];
  logic [DW-1:0] bank1 [FFT_SIZE];

  always @(posedge clk) begin
    if (mem0_ena) mem0_douta <= bank0[mem0_addra];
    if (mem0_enb) mem0_doutb <= bank0[mem0_addrb];
    if (mem1_ena) mem1_douta <= bank1[mem1_addra];
    if (mem1_enb) mem1_doutb <= bank1[mem1_addrb];
  end

  typedef struct { logic [DW-1:0] data; int cyc; } rd_exp_t;
  typedef struct { logic [DW-1:0] data; logic last; } beat_exp_t;

  rd_exp_t   qa[$];
  rd_exp_t   qb[$];
  beat_exp_t qd[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int issued = 0;
  int popped = 0;
  int beats = 0;
  logic drain_bank = 1'b0;
  logic          stall_q = 1'b0;
  logic [DW-1:0] stall_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] bank_rd(input logic id, input int a);
    return id ? bank1[a] : bank0[a];
  endfunction

  // Natural-order index: reverse the AW binary digits arithmetically.
  function automatic int rev_idx(input int i);
    int r = 0;
    int x = i;
    for (int k = 0; k < AW; k++) begin
      r = r * 2 + (x % 2);
      x = x / 2;
    end
    return r;
  endfunction

  // ------------------------------------------------------------- monitor
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_q = 1'b0;
    end else begin
      rd_exp_t   e;
      beat_exp_t b;
      if (fft_rvalida) begin
        if (qa.size() == 0) chk("rvalida_unexpected", 64'd1, 64'd0);
        else begin
          e = qa.pop_front();
          chk("rdataa", fft_rdataa, e.data);
          chk("rvalida_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
      if (fft_rvalidb) begin
        if (qb.size() == 0) chk("rvalidb_unexpected", 64'd1, 64'd0);
        else begin
          e = qb.pop_front();
          chk("rdatab", fft_rdatab, e.data);
          chk("rvalidb_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
      if (stall_q) begin
        chk("tvalid_hold", 64'(m_tvalid), 64'd1);
        chk("tdata_hold", m_tdata, stall_data);
      end
      stall_q    = m_tvalid && !m_tready;
      stall_data = m_tdata;
      if (drain_busy && (drain_bank ? mem1_ena : mem0_ena)) begin
        issued++;
        chk("outstanding_le_depth", 64'(issued - popped <= FIFO_DEPTH), 64'd1);
      end
      if (m_tvalid && m_tready) begin
        popped++;
        beats++;
        if (qd.size() == 0) chk("beat_unexpected", 64'd1, 64'd0);
        else begin
          b = qd.pop_front();
          chk("m_tdata", m_tdata, b.data);
          chk("m_tlast", 64'(m_tlast), 64'(b.last));
        end
      end
    end
  end

  // ------------------------------------------------------------ stimulus
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic fft_drive(input logic ea, input int aa, input logic eb, input int ab,
                           input logic id, input logic drop);
    fft_rea    = ea;
    fft_raddra = AW'(aa);
    fft_reb    = eb;
    fft_raddrb = AW'(ab);
    rmem_id    = id;
    if (ea && !drop) qa.push_back(rd_exp_t'{bank_rd(id, aa), cyc + RD_LAT});
    if (eb)          qb.push_back(rd_exp_t'{bank_rd(id, ab), cyc + RD_LAT});
  endtask

  task automatic fft_idle();
    fft_rea = 1'b0;
    fft_reb = 1'b0;
  endtask

  task automatic start_drain(input logic bank);
    issued     = 0;
    popped     = 0;
    beats      = 0;
    drain_bank = bank;
    for (int i = 0; i < FFT_SIZE; i++)
      qd.push_back(beat_exp_t'{bank_rd(bank, rev_idx(i)), (i == FFT_SIZE - 1)});
    drain_start  = 1'b1;
    drain_mem_id = bank;
    cycle();
    drain_start  = 1'b0;
    chk("busy_rise", 64'(drain_busy), 64'd1);
  endtask

  task automatic wait_done(input logic rand_ready);
    int n = 0;
    while (drain_busy && n < 1000) begin
      if (rand_ready) m_tready = ($urandom_range(0, 3) != 0);
      cycle();
      n++;
    end
    m_tready = 1'b1;
    chk("drain_done", 64'(drain_busy), 64'd0);
    chk("drain_beats", 64'(beats), 64'(FFT_SIZE));
    chk("drain_queue_empty", 64'(qd.size()), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < FFT_SIZE; i++) begin
      bank0[i] = {$urandom, $urandom};
      bank1[i] = {$urandom, $urandom};
    end
    bank0[5] = 64'hAAAA;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_enables", 64'({mem0_ena, mem0_enb, mem1_ena, mem1_enb}), 64'd0);
    chk("rst_addrs", 64'({mem0_addra, mem0_addrb, mem1_addra, mem1_addrb}), 64'd0);
    chk("rst_rvalid", 64'({fft_rvalida, fft_rvalidb}), 64'd0);
    chk("rst_rdataa", fft_rdataa, 64'd0);
    chk("rst_rdatab", fft_rdatab, 64'd0);
    chk("rst_busy", 64'(drain_busy), 64'd0);
    chk("rst_conflict", 64'(conflict_err), 64'd0);
    chk("rst_tvalid_tlast", 64'({m_tvalid, m_tlast}), 64'd0);
    rst_n = 1'b1;
    cycle();

    // Single read of bank 0, one-cycle latency
    fft_drive(1'b1, 5, 1'b0, 0, 1'b0, 1'b0);
    #1;
    chk("t1_mem0_ena", 64'(mem0_ena), 64'd1);
    chk("t1_mem0_addra", 64'(mem0_addra), 64'd5);
    chk("t1_mem1_ena", 64'(mem1_ena), 64'd0);
    cycle();
    fft_idle();
    chk("t1_rvalida", 64'(fft_rvalida), 64'd1);
    chk("t1_rdataa", fft_rdataa, 64'hAAAA);
    repeat (2) cycle();

    // Back-to-back reads alternating banks
    for (int i = 0; i < 8; i++) begin
      fft_drive(1'b1, $urandom_range(0, FFT_SIZE - 1), 1'b1,
                $urandom_range(0, FFT_SIZE - 1), i[0], 1'b0);
      cycle();
    end
    fft_idle();
    repeat (3) cycle();

    // Random FFT traffic
    for (int i = 0; i < 40; i++) begin
      fft_drive(1'($urandom_range(0, 1)), $urandom_range(0, FFT_SIZE - 1),
                1'($urandom_range(0, 1)), $urandom_range(0, FFT_SIZE - 1),
                1'($urandom_range(0, 1)), 1'b0);
      cycle();
    end
    fft_idle();
    repeat (3) cycle();

    // Full drain of bank 1, always ready
    m_tready = 1'b1;
    start_drain(1'b1);
    wait_done(1'b0);
    cycle();

    // Drain of bank 0 with 10 stalled cycles, ignored restart, random ready
    m_tready = 1'b0;
    start_drain(1'b0);
    for (int i = 0; i < 10; i++) begin
      drain_start  = (i == 5);
      drain_mem_id = 1'b1;
      cycle();
    end
    drain_start = 1'b0;
    wait_done(1'b1);
    cycle();

    // Conflict on the drained bank's port A
    m_tready = 1'b1;
    start_drain(1'b0);
    fft_drive(1'b1, 3, 1'b1, 7, 1'b0, 1'b1);
    cycle();
    chk("conflict_set", 64'(conflict_err), 64'd1);
    chk("conflict_rvalida", 64'(fft_rvalida), 64'd0);
    fft_drive(1'b1, 9, 1'b0, 0, 1'b1, 1'b0);
    cycle();
    fft_idle();
    chk("other_bank_rvalida", 64'(fft_rvalida), 64'd1);
    chk("other_bank_rdataa", fft_rdataa, bank1[9]);
    wait_done(1'b0);
    chk("conflict_sticky", 64'(conflict_err), 64'd1);
    cycle();

    // Reset in the middle of a drain
    start_drain(1'b0);
    begin
      int n = 0;
      while (beats < 5 && n < 200) begin
        cycle();
        n++;
      end
    end
    chk("mid_reset_reached_beat5", 64'(beats), 64'd5);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_tvalid", 64'(m_tvalid), 64'd0);
    chk("mid_reset_busy", 64'(drain_busy), 64'd0);
    qd.delete();
    repeat (2) cycle();
    rst_n = 1'b1;
    cycle();
    chk("post_reset_conflict", 64'(conflict_err), 64'd0);
    chk("post_reset_tvalid", 64'(m_tvalid), 64'd0);
    start_drain(1'b1);
    wait_done(1'b1);

    repeat (3) cycle();
    chk("qa_empty", 64'(qa.size()), 64'd0);
    chk("qb_empty", 64'(qb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/fft_mem_rd_mux.md
Name: fft_mem_rd_mux

Overview:
- Read-side companion to the FFT ping-pong memory write mux.
- Routes FFT-core butterfly reads (ports A/B) to one of two dual-port result banks selected by rmem_id, and re-aligns returned data to the bank's read latency.
- Contains a drain engine that streams a completed bank out over a valid/ready interface in bit-reversed (natural-order) sequence.
- Sits between the FFT core, the two bank RAMs and the downstream spectrum consumer.

Parameters:
- FFT_SIZE, 4096, points per transform; ADDR_WIDTH comes from fft_defs.vh (log2 FFT_SIZE = 12).
- DATA_WIDTH, 64, complex sample width (re/im packed).
- RD_LATENCY, 1, RAM read latency in cycles; legal values are 1 or 2.
- BITREV, 1, drain address order: 1 = bit-reversed counter, 0 = linear.
- FIFO_DEPTH, 4, drain output buffer entries; must be a power of 2 and at least RD_LATENCY+2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- fft_raddra  in  ADDR_WIDTH  FFT port-A read address
- fft_raddrb  in  ADDR_WIDTH  FFT port-B read address
- fft_rea  in  1  FFT port-A read enable
- fft_reb  in  1  FFT port-B read enable
- rmem_id  in  1  bank the FFT reads from (0/1)
- fft_rdataa  out  DATA_WIDTH  port-A read data
- fft_rdatab  out  DATA_WIDTH  port-B read data
- fft_rvalida  out  1  port-A data valid
- fft_rvalidb  out  1  port-B data valid
- memN_addra / memN_addrb  out  ADDR_WIDTH  bank N (N=0,1) read addresses
- memN_ena / memN_enb  out  1  bank N read enables
- memN_douta / memN_doutb  in  DATA_WIDTH  bank N read data
- drain_start  in  1  one-cycle pulse that starts a drain
- drain_mem_id  in  1  bank to drain, sampled with drain_start
- drain_busy  out  1  drain in progress
- conflict_err  out  1  sticky flag: FFT read collided with an active drain
- m_tdata  out  DATA_WIDTH  output sample
- m_tvalid  out  1  output valid
- m_tready  in  1  downstream ready
- m_tlast  out  1  marks sample FFT_SIZE-1

Behaviour:
- Reset values: all mem enables 0, addresses 0, fft_rvalida/b 0, fft_rdataa/b 0, drain_busy 0, conflict_err 0, m_tvalid 0, m_tlast 0. FIFO is empty, FSM is IDLE.
- FFT read path (both ports in parallel):
  - The request drives memN_addr/en combinationally, with N = rmem_id. The other bank's enables are 0.
  - A pipeline of RD_LATENCY stages carries {en, id}. Read data is selected from the delayed bank id; fft_rvalid equals the delayed en.
  - Total latency is RD_LATENCY cycles.
  - Back-to-back requests, including with alternating rmem_id, are fully pipelined with no bubbles.
- Drain FSM states are IDLE, RUN and FLUSH.
  - IDLE -> RUN on drain_start. At that edge, latch bank D = drain_mem_id and clear the counter to 0. drain_busy rises the cycle after drain_start.
  - RUN: issue a read on bank D port A at address BITREV ? bitrev(cnt) : cnt, only while fifo_count + inflight < FIFO_DEPTH. Increment cnt on each issue. After issuing cnt = FFT_SIZE-1, go to FLUSH.
  - FLUSH -> IDLE when inflight = 0, the FIFO is empty and the final beat has completed a handshake. drain_busy falls in the same cycle the FSM enters IDLE.
  - drain_start while busy is ignored.
  - Returned data enters the FIFO RD_LATENCY cycles after its issue. The FIFO never overflows because of the credit check above.
  - m_tvalid = FIFO not empty; m_tdata = FIFO head. A pop occurs on m_tvalid && m_tready.
  - m_tlast is asserted on the FFT_SIZE-th popped beat only.
  - Data presented while m_tready = 0 holds stable.
- Arbitration:
  - While drain_busy is high, the drain owns bank D port A. Both FFT ports to the other bank pass through normally, and FFT port B to bank D also passes.
  - An FFT port-A read to bank D while busy is dropped: its rvalid stays 0 and conflict_err sets. conflict_err clears only on reset.
- Reset mid-drain aborts immediately: the FIFO is flushed, the FSM returns to IDLE, m_tvalid drops asynchronously, and in-flight data is discarded.
- Counter width is ADDR_WIDTH+1 so that terminal detection needs no wrap.

Decomposition:
- Shared package: add an RD_LATENCY default constant and a bitrev function (ADDR_WIDTH wide) to fft_defs.vh / fft_pkg, reused by the FFT address generator.
- One sub-module: fft_rd_fifo, a synchronous FIFO (FIFO_DEPTH x DATA_WIDTH) providing count, push, pop, empty and full.

Test Plan:
- FFT path: rmem_id=0, fft_rea=1, raddra=0x005, with mem0_douta returning 0xAAAA → fft_rvalida=1 and fft_rdataa=0xAAAA exactly 1 cycle later; mem1_ena stays 0.
- Alternating banks: 8 back-to-back reads with rmem_id toggling each cycle → 8 consecutive valid beats with data from the correct bank each cycle and no gaps.
- Full drain with FFT_SIZE=16, BITREV=1, m_tready=1, bank 1 → 16 beats with addresses 0,8,4,12,2,…,15; m_tlast only on beat 16; drain_busy falls after beat 16.
- Backpressure during a drain: m_tready=0 for 10 cycles → no more than FIFO_DEPTH reads outstanding, m_tdata holds stable, no beats lost or duplicated (checked against scoreboard).
- Conflict: during a drain of bank 0, FFT port A reads bank 0 → fft_rvalida=0 and conflict_err=1. FFT reads of bank 1 on port A still return valid data.
- Reset mid-drain: assert rst_n=0 at beat 5 → m_tvalid=0 and drain_busy=0 immediately. A new drain_start after release produces a full FFT_SIZE-beat stream.
